phase_measure_reporter: RTL and testbench

Sits directly downstream of clocking_phase_measure in the phase-measurement clock domain and upstream of dprintf_4_async. Issues measure requests, filters and accumulates measure responses (count, sum, min, max, last, aborts, filtered). Every REPORT_INTERVAL accepted samples it emits one dprintf request carrying a statistics summary. Holds the request until acknowledged, then clears statistics and resumes measuring.

---
 rtl/phase_measure_reporter_if.sv | 53 +++++
 rtl/phase_measure_reporter.sv | 155 +++++++++++++++
 tb/tb_phase_measure_reporter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/phase_measure_reporter_if.sv
// Bus bundle between phase_measure_reporter and its neighbours.
//   measure_request__valid   : reporter -> clocking_phase_measure, request a measurement
//   measure_response__*      : clocking_phase_measure -> reporter, single-cycle result strobe
//   dprintf_req__*           : reporter -> dprintf_4_async, statistics report
//   dprintf_ack              : dprintf_4_async -> reporter, report accepted
// Modport master is the reporter side; slave is the environment side.
interface phase_measure_reporter_if;
  logic        measure_request__valid;
  logic        measure_response__valid;
  logic        measure_response__abort;
  logic        measure_response__initial_value;
  logic [8:0]  measure_response__delay;
  logic [8:0]  measure_response__initial_delay;
  logic        dprintf_req__valid;
  logic [15:0] dprintf_req__address;
  logic [63:0] dprintf_req__data_0;
  logic [63:0] dprintf_req__data_1;
  logic [63:0] dprintf_req__data_2;
  logic [63:0] dprintf_req__data_3;
  logic        dprintf_ack;

  modport master (
    output measure_request__valid,
    input  measure_response__valid,
    input  measure_response__abort,
    input  measure_response__initial_value,
    input  measure_response__delay,
    input  measure_response__initial_delay,
    output dprintf_req__valid,
    output dprintf_req__address,
    output dprintf_req__data_0,
    output dprintf_req__data_1,
    output dprintf_req__data_2,
    output dprintf_req__data_3,
    input  dprintf_ack
  );

  modport slave (
    input  measure_request__valid,
    output measure_response__valid,
    output measure_response__abort,
    output measure_response__initial_value,
    output measure_response__delay,
    output measure_response__initial_delay,
    input  dprintf_req__valid,
    input  dprintf_req__address,
    input  dprintf_req__data_0,
    input  dprintf_req__data_1,
    input  dprintf_req__data_2,
    input  dprintf_req__data_3,
    output dprintf_ack
  );
endinterface

// File: rtl/phase_measure_reporter.sv
// Phase measurement statistics reporter.
// Requests measurements, accumulates accepted responses (count, sum, min,
// max, last) plus abort and filtered counts, and every REPORT_INTERVAL
// accepted samples issues one dprintf request carrying the summary. The
// request is held until acknowledged; statistics are then cleared.
// Ports:
//   clk     : measurement clock, all state on rising edge
//   reset_n : asynchronous active-low reset
//   bus     : phase_measure_reporter_if.master (measure and dprintf buses)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_MEASURE | requesting measurements, accumulating responses
// ST_REPORT  | dprintf request held, responses ignored, waiting for ack
module phase_measure_reporter #(
  parameter int unsigned MIN_DELAY       = 16,
  parameter int unsigned REPORT_INTERVAL = 16,
  parameter int unsigned DPRINTF_ADDRESS = 80
) (
  input logic                       clk,
  input logic                       reset_n,
  phase_measure_reporter_if.master  bus
);

  localparam logic [8:0]  LP_MIN_DELAY = 9'(MIN_DELAY);
  localparam logic [15:0] LP_INTERVAL  = 16'(REPORT_INTERVAL);
  localparam logic [8:0]  LP_MIN_INIT  = 9'h1FF;

  typedef enum logic [0:0] {
    ST_MEASURE = 1'b0,
    ST_REPORT  = 1'b1
  } state_t;

  state_t      r_state, w_next_state;
  logic [15:0] r_sample_count, w_sample_count;
  logic [23:0] r_sum, w_sum;
  logic [8:0]  r_min, w_min;
  logic [8:0]  r_max, w_max;
  logic [8:0]  r_last, w_last;
  logic [15:0] r_abort_count, w_abort_count;
  logic [15:0] r_filtered_count, w_filtered_count;
  logic        r_initial_value, w_initial_value;
  logic [8:0]  r_initial_delay, w_initial_delay;
  logic        r_req_valid, w_req_valid;
  logic        r_dprintf_valid, w_dprintf_valid;
  logic [63:0] r_data_0, w_data_0;
  logic [63:0] r_data_1, w_data_1;

  // Initial value/delay are captured for observation only; nothing downstream
  // consumes them yet.
  logic w_unused_initial;
  assign w_unused_initial = ^{r_initial_value, r_initial_delay};

  always_comb begin
    w_next_state     = r_state;
    w_sample_count   = r_sample_count;
    w_sum            = r_sum;
    w_min            = r_min;
    w_max            = r_max;
    w_last           = r_last;
    w_abort_count    = r_abort_count;
    w_filtered_count = r_filtered_count;
    w_initial_value  = r_initial_value;
    w_initial_delay  = r_initial_delay;
    w_dprintf_valid  = r_dprintf_valid;
    w_data_0         = r_data_0;
    w_data_1         = r_data_1;

    case (r_state)
      ST_MEASURE: begin
        if (bus.measure_response__valid) begin
          w_initial_value = bus.measure_response__initial_value;
          w_initial_delay = bus.measure_response__initial_delay;
          if (bus.measure_response__abort) begin
            if (r_abort_count != 16'hFFFF) w_abort_count = r_abort_count + 16'd1;
          end else if (bus.measure_response__delay < LP_MIN_DELAY) begin
            if (r_filtered_count != 16'hFFFF) w_filtered_count = r_filtered_count + 16'd1;
          end else begin
            w_sample_count = r_sample_count + 16'd1;
            w_sum          = r_sum + {15'd0, bus.measure_response__delay};
            w_last         = bus.measure_response__delay;
            if (bus.measure_response__delay < r_min) w_min = bus.measure_response__delay;
            if (bus.measure_response__delay > r_max) w_max = bus.measure_response__delay;
            // Snapshot includes the triggering sample.
            if (w_sample_count == LP_INTERVAL) begin
              w_next_state    = ST_REPORT;
              w_dprintf_valid = 1'b1;
              w_data_0        = {7'h0, w_min, 7'h0, w_max, 8'h0, w_sum};
              w_data_1        = {w_sample_count, w_abort_count, w_filtered_count, 7'h0, w_last};
            end
          end
        end
      end
      ST_REPORT: begin
        if (bus.dprintf_ack && r_dprintf_valid) begin
          w_next_state     = ST_MEASURE;
          w_dprintf_valid  = 1'b0;
          w_sample_count   = 16'd0;
          w_sum            = 24'd0;
          w_min            = LP_MIN_INIT;
          w_max            = 9'd0;
          w_last           = 9'd0;
          w_abort_count    = 16'd0;
          w_filtered_count = 16'd0;
        end
      end
      default: w_next_state = ST_MEASURE;
    endcase

    w_req_valid = (w_next_state == ST_MEASURE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= ST_MEASURE;
      r_sample_count   <= 16'd0;
      r_sum            <= 24'd0;
      r_min            <= LP_MIN_INIT;
      r_max            <= 9'd0;
      r_last           <= 9'd0;
      r_abort_count    <= 16'd0;
      r_filtered_count <= 16'd0;
      r_initial_value  <= 1'b0;
      r_initial_delay  <= 9'd0;
      r_req_valid      <= 1'b0;
      r_dprintf_valid  <= 1'b0;
      r_data_0         <= 64'd0;
      r_data_1         <= 64'd0;
    end else begin
      r_state          <= w_next_state;
      r_sample_count   <= w_sample_count;
      r_sum            <= w_sum;
      r_min            <= w_min;
      r_max            <= w_max;
      r_last           <= w_last;
      r_abort_count    <= w_abort_count;
      r_filtered_count <= w_filtered_count;
      r_initial_value  <= w_initial_value;
      r_initial_delay  <= w_initial_delay;
      r_req_valid      <= w_req_valid;
      r_dprintf_valid  <= w_dprintf_valid;
      r_data_0         <= w_data_0;
      r_data_1         <= w_data_1;
    end
  end

  assign bus.measure_request__valid = r_req_valid;
  assign bus.dprintf_req__valid     = r_dprintf_valid;
  assign bus.dprintf_req__address   = 16'(DPRINTF_ADDRESS);
  assign bus.dprintf_req__data_0    = r_data_0;
  assign bus.dprintf_req__data_1    = r_data_1;
  assign bus.dprintf_req__data_2    = {64{1'b1}};
  assign bus.dprintf_req__data_3    = {64{1'b1}};

endmodule

// File: tb/tb_phase_measure_reporter.sv
module tb_phase_measure_reporter;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  phase_measure_reporter_if if_a ();
  phase_measure_reporter_if if_b ();

  phase_measure_reporter #(.MIN_DELAY(16), .REPORT_INTERVAL(4), .DPRINTF_ADDRESS(80)) u_dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_a)
  );

  phase_measure_reporter #(.MIN_DELAY(16), .REPORT_INTERVAL(2), .DPRINTF_ADDRESS(80)) u_dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic        abrt;
    logic [8:0]  dly;
    logic        ack;
    logic        exp_req;
    logic        exp_dv;
    logic        chk_data;
    logic [63:0] exp_d0;
    logic [63:0] exp_d1;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One response strobe on DUT A, sampled by the next rising edge.
  task automatic resp_a(input logic abrt, input logic [8:0] dly);
    if_a.measure_response__valid = 1'b1;
    if_a.measure_response__abort = abrt;
    if_a.measure_response__delay = dly;
    tick();
    if_a.measure_response__valid = 1'b0;
    if_a.measure_response__abort = 1'b0;
  endtask

  task automatic resp_b(input logic abrt, input logic [8:0] dly);
    if_b.measure_response__valid = 1'b1;
    if_b.measure_response__abort = abrt;
    if_b.measure_response__delay = dly;
    tick();
    if_b.measure_response__valid = 1'b0;
    if_b.measure_response__abort = 1'b0;
  endtask

  task automatic ack_a(input string name);
    if_a.dprintf_ack = 1'b1;
    tick();
    if_a.dprintf_ack = 1'b0;
    check({name, "_dv_after_ack"}, 64'(if_a.dprintf_req__valid), 64'd0);
    check({name, "_req_after_ack"}, 64'(if_a.measure_request__valid), 64'd1);
  endtask

  task automatic check_report_a(input string name, input logic [63:0] d0, input logic [63:0] d1);
    check({name, "_dv"}, 64'(if_a.dprintf_req__valid), 64'd1);
    check({name, "_req"}, 64'(if_a.measure_request__valid), 64'd0);
    check({name, "_d0"}, if_a.dprintf_req__data_0, d0);
    check({name, "_d1"}, if_a.dprintf_req__data_1, d1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    if_a.measure_response__valid = 1'b0;
    if_a.measure_response__abort = 1'b0;
    if_a.measure_response__initial_value = 1'b0;
    if_a.measure_response__delay = 9'd0;
    if_a.measure_response__initial_delay = 9'd0;
    if_a.dprintf_ack = 1'b0;
    if_b.measure_response__valid = 1'b0;
    if_b.measure_response__abort = 1'b0;
    if_b.measure_response__initial_value = 1'b1;
    if_b.measure_response__delay = 9'd0;
    if_b.measure_response__initial_delay = 9'd3;
    if_b.dprintf_ack = 1'b0;

    vecs[0]  = '{1, 0, 9'd20,  0, 1, 0, 0, 64'd0, 64'd0};
    vecs[1]  = '{1, 0, 9'd30,  0, 1, 0, 0, 64'd0, 64'd0};
    vecs[2]  = '{1, 0, 9'd25,  0, 1, 0, 0, 64'd0, 64'd0};
    vecs[3]  = '{1, 0, 9'd40,  0, 0, 1, 1,
                 {7'h0, 9'd20, 7'h0, 9'd40, 8'h0, 24'd115}, {16'd4, 16'd0, 16'd0, 7'h0, 9'd40}};
    vecs[4]  = '{0, 0, 9'd0,   0, 0, 1, 1,
                 {7'h0, 9'd20, 7'h0, 9'd40, 8'h0, 24'd115}, {16'd4, 16'd0, 16'd0, 7'h0, 9'd40}};
    vecs[5]  = '{0, 0, 9'd0,   1, 1, 0, 0, 64'd0, 64'd0};
    vecs[6]  = '{0, 0, 9'd0,   1, 1, 0, 0, 64'd0, 64'd0};
    vecs[7]  = '{1, 0, 9'd100, 0, 1, 0, 0, 64'd0, 64'd0};
    vecs[8]  = '{1, 0, 9'd50,  0, 1, 0, 0, 64'd0, 64'd0};
    vecs[9]  = '{1, 0, 9'd60,  0, 1, 0, 0, 64'd0, 64'd0};
    vecs[10] = '{1, 0, 9'd70,  0, 0, 1, 1,
                 {7'h0, 9'd50, 7'h0, 9'd100, 8'h0, 24'd280}, {16'd4, 16'd0, 16'd0, 7'h0, 9'd70}};
    vecs[11] = '{0, 0, 9'd0,   1, 1, 0, 0, 64'd0, 64'd0};

    // Reset values
    tick();
    tick();
    check("rst_req", 64'(if_a.measure_request__valid), 64'd0);
    check("rst_dv", 64'(if_a.dprintf_req__valid), 64'd0);
    check("rst_d0", if_a.dprintf_req__data_0, 64'd0);
    check("rst_d1", if_a.dprintf_req__data_1, 64'd0);
    check("rst_addr", 64'(if_a.dprintf_req__address), 64'd80);
    check("rst_d2", if_a.dprintf_req__data_2, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_d3", if_a.dprintf_req__data_3, 64'hFFFF_FFFF_FFFF_FFFF);
    reset_n = 1'b1;
    tick();
    check("post_rst_req_a", 64'(if_a.measure_request__valid), 64'd1);
    check("post_rst_req_b", 64'(if_b.measure_request__valid), 64'd1);
    begin
      int seen_dv = 0;
      for (int i = 0; i < 100; i++) begin
        tick();
        if (if_a.dprintf_req__valid !== 1'b0 || if_a.measure_request__valid !== 1'b1) seen_dv++;
      end
      check("idle_100_cycles", 64'(seen_dv), 64'd0);
    end

    // Table: interval 4 basic report, ack on 3rd valid cycle, stray ack, second report
    for (int i = 0; i < 12; i++) begin
      if_a.measure_response__valid = vecs[i].vld;
      if_a.measure_response__abort = vecs[i].abrt;
      if_a.measure_response__delay = vecs[i].dly;
      if_a.dprintf_ack             = vecs[i].ack;
      tick();
      if_a.measure_response__valid = 1'b0;
      if_a.dprintf_ack             = 1'b0;
      check($sformatf("vec%0d_req", i), 64'(if_a.measure_request__valid), 64'(vecs[i].exp_req));
      check($sformatf("vec%0d_dv", i), 64'(if_a.dprintf_req__valid), 64'(vecs[i].exp_dv));
      if (vecs[i].chk_data) begin
        check($sformatf("vec%0d_d0", i), if_a.dprintf_req__data_0, vecs[i].exp_d0);
        check($sformatf("vec%0d_d1", i), if_a.dprintf_req__data_1, vecs[i].exp_d1);
        check($sformatf("vec%0d_addr", i), 64'(if_a.dprintf_req__address), 64'd80);
        check($sformatf("vec%0d_d2", i), if_a.dprintf_req__data_2, 64'hFFFF_FFFF_FFFF_FFFF);
      end
    end

    // Interval 2 mix on DUT B: aborts and filtered never trigger
    resp_b(1'b1, 9'd0);
    resp_b(1'b0, 9'd5);
    resp_b(1'b0, 9'd16);
    check("mix_no_trigger_dv", 64'(if_b.dprintf_req__valid), 64'd0);
    resp_b(1'b1, 9'd0);
    check("mix_abort_no_trigger", 64'(if_b.dprintf_req__valid), 64'd0);
    resp_b(1'b0, 9'd17);
    check("mix_dv", 64'(if_b.dprintf_req__valid), 64'd1);
    check("mix_d0", if_b.dprintf_req__data_0, {7'h0, 9'd16, 7'h0, 9'd17, 8'h0, 24'd33});
    check("mix_d1", if_b.dprintf_req__data_1, {16'd2, 16'd2, 16'd1, 7'h0, 9'd17});
    if_b.dprintf_ack = 1'b1;
    tick();
    if_b.dprintf_ack = 1'b0;
    check("mix_dv_after_ack", 64'(if_b.dprintf_req__valid), 64'd0);
    check("mix_req_after_ack", 64'(if_b.measure_request__valid), 64'd1);

    // Responses during REPORT are ignored while ack is withheld
    resp_a(1'b0, 9'd30);
    resp_a(1'b0, 9'd31);
    resp_a(1'b0, 9'd32);
    resp_a(1'b0, 9'd33);
    for (int i = 0; i < 50; i++) begin
      if_a.measure_response__valid = (i % 3 == 0);
      if_a.measure_response__abort = (i % 6 == 0);
      if_a.measure_response__delay = 9'd200;
      tick();
    end
    if_a.measure_response__valid = 1'b0;
    if_a.measure_response__abort = 1'b0;
    check_report_a("hold50", {7'h0, 9'd30, 7'h0, 9'd33, 8'h0, 24'd126}, {16'd4, 16'd0, 16'd0, 7'h0, 9'd33});
    ack_a("hold50");
    resp_a(1'b0, 9'd18);
    resp_a(1'b0, 9'd19);
    resp_a(1'b0, 9'd20);
    resp_a(1'b0, 9'd21);
    check_report_a("post_hold", {7'h0, 9'd18, 7'h0, 9'd21, 8'h0, 24'd78}, {16'd4, 16'd0, 16'd0, 7'h0, 9'd21});
    ack_a("post_hold");

    // Abort counter saturation, plus the MIN_DELAY boundary (15 filtered, 16 accepted)
    if_a.measure_response__valid = 1'b1;
    if_a.measure_response__abort = 1'b1;
    for (int i = 0; i < 70000; i++) tick();
    if_a.measure_response__valid = 1'b0;
    if_a.measure_response__abort = 1'b0;
    check("sat_no_trigger", 64'(if_a.dprintf_req__valid), 64'd0);
    resp_a(1'b0, 9'd15);
    resp_a(1'b0, 9'd16);
    resp_a(1'b0, 9'd16);
    resp_a(1'b0, 9'd16);
    check("boundary_no_trigger", 64'(if_a.dprintf_req__valid), 64'd0);
    resp_a(1'b0, 9'd16);
    check_report_a("sat", {7'h0, 9'd16, 7'h0, 9'd16, 8'h0, 24'd64}, {16'd4, 16'hFFFF, 16'd1, 7'h0, 9'd16});
    ack_a("sat");

    // Reset mid-REPORT
    resp_a(1'b0, 9'd50);
    resp_a(1'b0, 9'd50);
    resp_a(1'b0, 9'd50);
    resp_a(1'b1, 9'd0);
    resp_a(1'b0, 9'd50);
    tick();
    check("pre_rst_dv", 64'(if_a.dprintf_req__valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_dv", 64'(if_a.dprintf_req__valid), 64'd0);
    check("midrst_req", 64'(if_a.measure_request__valid), 64'd0);
    tick();
    reset_n = 1'b1;
    begin
      int reissue = 0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (if_a.dprintf_req__valid !== 1'b0) reissue++;
      end
      check("no_reissue", 64'(reissue), 64'd0);
    end
    check("post_midrst_req", 64'(if_a.measure_request__valid), 64'd1);
    resp_a(1'b0, 9'd100);
    resp_a(1'b0, 9'd101);
    resp_a(1'b0, 9'd102);
    resp_a(1'b0, 9'd103);
    check_report_a("post_rst", {7'h0, 9'd100, 7'h0, 9'd103, 8'h0, 24'd406}, {16'd4, 16'd0, 16'd0, 7'h0, 9'd103});
    ack_a("post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
